// File: rtl/ft_cla_pipe_if.sv
// Valid/ready datapath bundle for ft_cla_pipe: operand beat in, voted result beat out.
// The master side drives operands and out_ready; the slave side is the adder.
interface ft_cla_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       fault_inj;
  logic [WIDTH:0]   fault_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err_corr;
  logic             err_multi;

  modport master (
    output in_valid, a, b, cin, fault_inj, fault_mask, out_ready,
    input  in_ready, out_valid, sum, cout, err_corr, err_multi
  );

  modport slave (
    input  in_valid, a, b, cin, fault_inj, fault_mask, out_ready,
    output in_ready, out_valid, sum, cout, err_corr, err_multi
  );
endinterface

// File: rtl/ft_cla_pipe.sv
// Two-stage, triple-modular-redundant carry-look-ahead adder behind a valid/ready handshake.
// ft_cla_core is one replica: 4-bit look-ahead groups joined by a second-level look-ahead.
module ft_cla_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   res
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g, p, c;
  logic [NG-1:0]    gg, gp;
  logic [NG:0]      gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Each group carry is a flat sum of products over all lower groups, not a ripple chain.
  always_comb begin
    logic t;
    logic acc;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      t = cin;
      for (int m = 0; m <= k; m++) t = t & gp[m];
      acc = t;
      for (int j = 0; j <= k; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= k; m++) t = t & gp[m];
        acc = acc | t;
      end
      gc[k+1] = acc;
    end
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign res = {gc[NG], p ^ c};
endmodule

module ft_cla_pipe #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ft_cla_pipe_if.slave      bus,
  input  logic              clr_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [2:0]        replica_fail
);
  localparam int NREP = 3;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [NREP-1:0]  fault_inj;
    logic [WIDTH:0]   fault_mask;
  } req_t;

  typedef struct packed {
    logic [WIDTH:0]  word;
    logic            err_corr;
    logic            err_multi;
    logic [NREP-1:0] diff;
  } rsp_t;

  logic [1:0]                 rst_sync;
  logic                       s1_valid, out_valid;
  logic                       out_adv, rdy, out_hs;
  req_t                       s1;
  rsp_t                       s2, out_q;
  logic [NREP-1:0][WIDTH:0]   rep_raw, rep;

  // Flops clear asynchronously, but new beats are only taken once the release has synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign out_adv      = ~out_valid | bus.out_ready;
  assign rdy          = rst_sync[1] & (~s1_valid | out_adv);
  assign out_hs       = out_valid & bus.out_ready;
  assign bus.in_ready = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (rdy) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1.a          <= bus.a;
        s1.b          <= bus.b;
        s1.cin        <= bus.cin;
        s1.fault_inj  <= bus.fault_inj;
        s1.fault_mask <= bus.fault_mask;
      end
    end
  end

  for (genvar r = 0; r < NREP; r++) begin : g_rep
    ft_cla_core #(.WIDTH(WIDTH)) u_core (
      .a   (s1.a),
      .b   (s1.b),
      .cin (s1.cin),
      .res (rep_raw[r])
    );
    assign rep[r] = rep_raw[r] ^ (s1.fault_inj[r] ? s1.fault_mask : '0);
  end

  // Two replicas corrupted identically outvote the good one; diff then blames the good replica.
  always_comb begin
    s2      = '0;
    s2.word = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
    for (int r = 0; r < NREP; r++) s2.diff[r] = |(rep[r] ^ s2.word);
    s2.err_corr  = $onehot(s2.diff);
    s2.err_multi = (s2.diff[0] & s2.diff[1]) | (s2.diff[0] & s2.diff[2])
                 | (s2.diff[1] & s2.diff[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_q <= s2;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.sum       = out_q.word[WIDTH-1:0];
  assign bus.cout      = out_q.word[WIDTH];
  assign bus.err_corr  = out_q.err_corr;
  assign bus.err_multi = out_q.err_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      replica_fail <= '0;
    end else if (clr_err) begin
      err_count    <= '0;
      replica_fail <= '0;
    end else if (out_hs) begin
      if ((out_q.err_corr | out_q.err_multi) && (err_count != '1))
        err_count <= err_count + 1'b1;
      replica_fail <= replica_fail | out_q.diff;
    end
  end
endmodule

// File: tb/tb_ft_cla_pipe.sv
// Scoreboard bench for ft_cla_pipe: driver queues model results on acceptance, monitor
// compares every presented output beat and the error bookkeeping on each handshake.
module tb_ft_cla_pipe;
  localparam int WIDTH = 16;
  localparam int ERR_W = 4;
  localparam int CMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_err = 1'b0;
  logic [ERR_W-1:0] err_count;
  logic [2:0]       replica_fail;

  ft_cla_pipe_if #(.WIDTH(WIDTH)) bus ();

  ft_cla_pipe #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr_err      (clr_err),
    .err_count    (err_count),
    .replica_fail (replica_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] word;
    logic           corr;
    logic           multi;
    logic [2:0]     diff;
  } exp_t;

  exp_t           q[$];
  int             tests = 0, fails = 0, issued = 0, delivered = 0, exp_cnt = 0;
  logic [2:0]     exp_rf = '0;
  logic [WIDTH:0] last_word = '0;
  logic           last_corr = 1'b0, last_multi = 1'b0;
  bit             rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true sum, corrupt the selected replicas, then vote bit by bit by counting.
  function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic c_i, input logic [2:0] fi, input logic [WIDTH:0] fm);
    exp_t           e;
    logic [WIDTH:0] truth;
    logic [WIDTH:0] r [3];
    int             votes, nd;
    truth = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i) + (WIDTH+1)'(c_i);
    for (int i = 0; i < 3; i++) r[i] = fi[i] ? (truth ^ fm) : truth;
    for (int k = 0; k <= WIDTH; k++) begin
      votes = int'(r[0][k]) + int'(r[1][k]) + int'(r[2][k]);
      e.word[k] = (votes >= 2);
    end
    for (int i = 0; i < 3; i++) e.diff[i] = (r[i] != e.word);
    nd      = $countones(e.diff);
    e.corr  = (nd == 1);
    e.multi = (nd >= 2);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic send(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i, input logic c_i,
                      input logic [2:0] fi, input logic [WIDTH:0] fm);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.a          = a_i;
    bus.b          = b_i;
    bus.cin        = c_i;
    bus.fault_inj  = fi;
    bus.fault_mask = fm;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(model(a_i, b_i, c_i, fi, fm));
        issued++;
        break;
      end
      n++;
      if (n > 500) begin
        check("send_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  // Monitor: every presented beat must match the head; bookkeeping is checked on handshakes.
  initial begin : monitor
    logic hs;
    exp_t h;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hs = bus.out_valid & bus.out_ready;
        h  = '{default: '0};
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 32'(bus.out_valid), 32'd0);
            hs = 1'b0;
          end else begin
            h = q[0];
            check("sum",       32'(bus.sum),       32'(h.word[WIDTH-1:0]));
            check("cout",      32'(bus.cout),      32'(h.word[WIDTH]));
            check("err_corr",  32'(bus.err_corr),  32'(h.corr));
            check("err_multi", 32'(bus.err_multi), 32'(h.multi));
            if (hs) begin
              check("err_count",    32'(err_count),    32'(exp_cnt));
              check("replica_fail", 32'(replica_fail), 32'(exp_rf));
              last_word  = {bus.cout, bus.sum};
              last_corr  = bus.err_corr;
              last_multi = bus.err_multi;
              void'(q.pop_front());
              delivered++;
            end
          end
        end
        if (clr_err) begin
          exp_cnt = 0;
          exp_rf  = '0;
        end else if (hs) begin
          if ((h.corr || h.multi) && exp_cnt < CMAX) exp_cnt++;
          exp_rf = exp_rf | h.diff;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus.fault_inj  = '0;
    bus.fault_mask = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_err_count", 32'(err_count),     32'd0);
    check("rst_rfail",     32'(replica_fail),  32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Carry ripple across all groups plus two-cycle latency
    send(16'hFFFF, 16'h0001, 1'b0, 3'b000, '0);
    @(negedge clk);
    check("lat_s1_only", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("ripple_sum",    32'(bus.sum),       32'h0000);
    check("ripple_cout",   32'(bus.cout),      32'd1);
    @(posedge clk); #1;
    drain();
    send(16'h1234, 16'h1111, 1'b1, 3'b000, '0);
    drain();
    check("cin_word", 32'(last_word), 32'h02346);

    // Single fault on replica 1
    send(16'h1234, 16'h1111, 1'b0, 3'b010, 17'h00001);
    drain();
    check("sf_word",   32'(last_word),    32'h02345);
    check("sf_corr",   32'(last_corr),    32'd1);
    check("sf_multi",  32'(last_multi),   32'd0);
    check("sf_count",  32'(err_count),    32'd1);
    check("sf_rfail",  32'(replica_fail), 32'b010);

    // Distinct faults in separate beats, then the shared-mask voter limitation
    send(16'h1234, 16'h1111, 1'b0, 3'b001, 17'h00001);
    send(16'h1234, 16'h1111, 1'b0, 3'b010, 17'h00002);
    drain();
    check("df_rfail", 32'(replica_fail), 32'b011);
    check("df_count", 32'(err_count),    32'd3);
    send(16'h1234, 16'h1111, 1'b0, 3'b011, 17'h00003);
    drain();
    check("lim_word",  32'(last_word),    32'h02346);
    check("lim_corr",  32'(last_corr),    32'd1);
    check("lim_multi", 32'(last_multi),   32'd0);
    check("lim_rfail", 32'(replica_fail), 32'b111);

    // Back-pressure: two beats fill the pipe, third waits until out_ready rises
    bus.out_ready = 1'b0;
    send(16'h0A0A, 16'h0101, 1'b0, 3'b000, '0);
    send(16'h0B0B, 16'h0202, 1'b0, 3'b000, '0);
    @(negedge clk);
    check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold_sum",  32'(bus.sum),       32'h0B0B);
    @(posedge clk); #1;
    fork
      send(16'h0C0C, 16'h0303, 1'b0, 3'b000, '0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_order_word", 32'(last_word), 32'h00F0F);
    check("bp_no_loss", 32'(delivered), 32'(issued));

    // Randomized traffic with random stalls, faults and occasional clears
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [WIDTH-1:0] ra, rb;
          logic [2:0]       fi;
          logic [WIDTH:0]   fm;
          ra = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
          rb = 16'($urandom);
          fi = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
          fm = ($urandom_range(0, 1) == 0) ? (17'd1 << $urandom_range(0, WIDTH))
                                           : 17'($urandom);
          send(ra, rb, 1'($urandom), fi, fm);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          clr_err       = ($urandom_range(0, 29) == 0);
        end
        bus.out_ready = 1'b1;
        clr_err       = 1'b0;
      end
    join
    drain();

    // Saturation, then clear winning over a same-cycle erroring handshake
    clear_pulse();
    for (int i = 0; i < 17; i++) send(16'($urandom), 16'($urandom), 1'b0, 3'b100, 17'h10000);
    drain();
    check("sat_count", 32'(err_count),    32'd15);
    check("sat_rfail", 32'(replica_fail), 32'b100);
    bus.out_ready = 1'b0;
    send(16'h0005, 16'h0006, 1'b0, 3'b001, 17'h00001);
    @(posedge clk); #1;
    clr_err       = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    check("clr_prio_count", 32'(err_count),    32'd0);
    check("clr_prio_rfail", 32'(replica_fail), 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset with beats in flight
    send(16'h0001, 16'h0001, 1'b0, 3'b001, 17'h00004);
    drain();
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 3'b010, 17'h00001);
    send(16'h3333, 16'h4444, 1'b0, 3'b000, '0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum",       32'(bus.sum),       32'd0);
    check("mid_rst_cout",      32'(bus.cout),      32'd0);
    check("mid_rst_err_count", 32'(err_count),     32'd0);
    check("mid_rst_rfail",     32'(replica_fail),  32'd0);
    q.delete();
    exp_cnt   = 0;
    exp_rf    = '0;
    issued    = 0;
    delivered = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h8000, 16'h8000, 1'b1, 3'b000, '0);
    drain();
    check("after_rst_word", 32'(last_word),  32'h10001);
    check("final_no_loss",  32'(delivered),  32'(issued));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
